// File: rtl/s2h_pkt_gate_pkg.sv
// Shared definitions for the s2h store-and-forward packet gate.
package s2h_pkt_gate_pkg;

    // Write-side FSM: accept words into the buffer, or discard an oversize packet
    typedef enum logic [0:0] {
        StFill = 1'b0,
        StDrop = 1'b1
    } wr_state_e;

    // Width of the lifetime statistics counters
    localparam int unsigned StatsW = 32;

    // Pointers carry one extra MSB so that full and empty are distinguishable
    function automatic int unsigned ptr_width(input int unsigned size);
        return size + 1;
    endfunction

endpackage

// File: rtl/s2h_pkt_gate_ram.sv
// Simple dual-port RAM with a registered read port, intended for block RAM inference.
// rd_data only changes on rd_en, so the consumer may treat it as a holding register.
module s2h_pkt_gate_ram #(
    parameter int unsigned Width = 65,
    parameter int unsigned AddrW = 10
) (
    input  logic             bus_clk,
    input  logic             wr_en,
    input  logic [AddrW-1:0] wr_addr,
    input  logic [Width-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AddrW-1:0] rd_addr,
    output logic [Width-1:0] rd_data
);

    logic [Width-1:0] mem [2**AddrW];

    // Write port and registered read port
    always_ff @(posedge bus_clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/s2h_pkt_gate.sv
// Store-and-forward packet gate between the crossbar host port and the DMA data mover.
// A packet becomes visible downstream only once its tlast word is written; packets
// longer than the buffer are discarded whole.
// Optional build macro S2H_PKT_GATE_STATS_EN adds the drop_total / fwd_total counters.
module s2h_pkt_gate
    import s2h_pkt_gate_pkg::*;
#(
    parameter int unsigned WIDTH     = 64,
    parameter int unsigned SIZE      = 10,
    parameter int unsigned PKT_CNT_W = 8
) (
    input  logic                 bus_clk,
    input  logic                 bus_rst,
    input  logic                 clear,
    input  logic [WIDTH-1:0]     i_tdata,
    input  logic                 i_tlast,
    input  logic                 i_tvalid,
    output logic                 i_tready,
    output logic [WIDTH-1:0]     o_tdata,
    output logic                 o_tlast,
    output logic                 o_tvalid,
    input  logic                 o_tready,
    output logic [PKT_CNT_W-1:0] pkt_count,
    output logic                 drop_pulse
`ifdef S2H_PKT_GATE_STATS_EN
    ,
    output logic [StatsW-1:0]    drop_total,
    output logic [StatsW-1:0]    fwd_total
`endif
);

    localparam int unsigned PtrW = ptr_width(SIZE);
    localparam int unsigned EntW = WIDTH + 1;
    localparam logic [PtrW-1:0]      PtrOne = PtrW'(1);
    localparam logic [PKT_CNT_W-1:0] CntOne = PKT_CNT_W'(1);

    wr_state_e            state_q;
    logic [PtrW-1:0]      wr_ptr_q, wr_base_q, rd_ptr_q, fetch_ptr_q;
    logic [PKT_CNT_W-1:0] pkt_count_q;
    logic                 drop_pulse_q;
    logic                 ram_vld_q, skid_vld_q;
    logic [EntW-1:0]      skid_q;
    logic [EntW-1:0]      ram_rd_data;

    logic [PtrW-1:0] occupancy;
    logic            full, cnt_sat, overflow, in_acc, wr_en, commit, drop_evt;
    logic            out_acc, retire, fetch_en;
    logic [EntW-1:0] head;

    // Handshake decode, buffer status and output head selection
    always_comb begin
        occupancy = wr_ptr_q - rd_ptr_q;
        // Occupancy never exceeds 2^SIZE, so the MSB alone flags full
        full      = occupancy[SIZE];
        cnt_sat   = &pkt_count_q;
        // Only the open packet occupies the whole buffer: it can never fit
        overflow  = (state_q == StFill) && full && (pkt_count_q == '0);
        // Gated by the raw reset so upstream sees not-ready while reset is held
        i_tready  = !bus_rst && ((state_q == StDrop) || overflow || (!full && !cnt_sat));
        in_acc    = i_tvalid && i_tready;
        wr_en     = (state_q == StFill) && in_acc && !overflow;
        commit    = wr_en && i_tlast;
        drop_evt  = in_acc && i_tlast && ((state_q == StDrop) || overflow);

        // Skid register holds the older word when both stages are occupied
        head      = skid_vld_q ? skid_q : (ram_vld_q ? ram_rd_data : '0);
        o_tvalid  = skid_vld_q || ram_vld_q;
        o_tdata   = head[WIDTH-1:0];
        o_tlast   = head[WIDTH];
        out_acc   = o_tvalid && o_tready;
        retire    = out_acc && o_tlast;
        // Prefetch committed words only; never overwrite RAM data that is still held
        fetch_en  = (fetch_ptr_q != wr_base_q) && !(ram_vld_q && skid_vld_q);

        pkt_count  = pkt_count_q;
        drop_pulse = drop_pulse_q;
    end

    // Write-side FSM: store and commit packets, rewind and discard oversize ones
    always_ff @(posedge bus_clk or posedge bus_rst) begin
        if (bus_rst) begin
            state_q      <= StFill;
            wr_ptr_q     <= '0;
            wr_base_q    <= '0;
            drop_pulse_q <= 1'b0;
        end else if (clear) begin
            state_q      <= StFill;
            wr_ptr_q     <= '0;
            wr_base_q    <= '0;
            drop_pulse_q <= 1'b0;
        end else begin
            drop_pulse_q <= drop_evt;
            unique case (state_q)
                StFill: begin
                    if (overflow) begin
                        wr_ptr_q <= wr_base_q;
                        // A tlast on the overflowing word ends the drop immediately
                        if (!(in_acc && i_tlast)) begin
                            state_q <= StDrop;
                        end
                    end else if (in_acc) begin
                        wr_ptr_q <= wr_ptr_q + PtrOne;
                        if (i_tlast) begin
                            wr_base_q <= wr_ptr_q + PtrOne;
                        end
                    end
                end
                StDrop: begin
                    if (in_acc && i_tlast) begin
                        state_q <= StFill;
                    end
                end
                default: state_q <= StFill;
            endcase
        end
    end

    // Read side: RAM prefetch, skid register, read pointer and packet count
    always_ff @(posedge bus_clk or posedge bus_rst) begin
        if (bus_rst) begin
            rd_ptr_q    <= '0;
            fetch_ptr_q <= '0;
            pkt_count_q <= '0;
            ram_vld_q   <= 1'b0;
            skid_vld_q  <= 1'b0;
            skid_q      <= '0;
        end else if (clear) begin
            rd_ptr_q    <= '0;
            fetch_ptr_q <= '0;
            pkt_count_q <= '0;
            ram_vld_q   <= 1'b0;
            skid_vld_q  <= 1'b0;
            skid_q      <= '0;
        end else begin
            if (out_acc) begin
                rd_ptr_q <= rd_ptr_q + PtrOne;
            end
            if (fetch_en) begin
                fetch_ptr_q <= fetch_ptr_q + PtrOne;
            end
            if (commit && !retire) begin
                pkt_count_q <= pkt_count_q + CntOne;
            end else if (retire && !commit) begin
                pkt_count_q <= pkt_count_q - CntOne;
            end
            ram_vld_q <= fetch_en || (ram_vld_q && !out_acc);
            if (skid_vld_q) begin
                if (out_acc) begin
                    skid_vld_q <= ram_vld_q;
                    skid_q     <= ram_rd_data;
                end
            end else if (ram_vld_q && !out_acc && fetch_en) begin
                skid_vld_q <= 1'b1;
                skid_q     <= ram_rd_data;
            end
        end
    end

`ifdef S2H_PKT_GATE_STATS_EN
    localparam logic [StatsW-1:0] StatsOne = StatsW'(1);

    logic [StatsW-1:0] drop_total_q, fwd_total_q;

    // Lifetime counters survive clear; only bus_rst zeroes them
    always_ff @(posedge bus_clk or posedge bus_rst) begin
        if (bus_rst) begin
            drop_total_q <= '0;
            fwd_total_q  <= '0;
        end else begin
            if (drop_evt && !clear) begin
                drop_total_q <= drop_total_q + StatsOne;
            end
            if (retire) begin
                fwd_total_q <= fwd_total_q + StatsOne;
            end
        end
    end

    assign drop_total = drop_total_q;
    assign fwd_total  = fwd_total_q;
`endif

    s2h_pkt_gate_ram #(
        .Width(EntW),
        .AddrW(SIZE)
    ) u_ram (
        .bus_clk(bus_clk),
        .wr_en  (wr_en),
        .wr_addr(wr_ptr_q[SIZE-1:0]),
        .wr_data({i_tlast, i_tdata}),
        .rd_en  (fetch_en),
        .rd_addr(fetch_ptr_q[SIZE-1:0]),
        .rd_data(ram_rd_data)
    );

endmodule

// File: tb/tb_s2h_pkt_gate.sv
// Bench for s2h_pkt_gate: directed scenarios plus randomized traffic, checked against a
// packet-level reference model (packets of at most Depth words forwarded in order,
// longer ones dropped whole).
module tb_s2h_pkt_gate;

    localparam int unsigned Width = 64;
    localparam int unsigned Size  = 4;
    localparam int unsigned CntW  = 3;
    localparam int          Depth = 16;

    typedef logic [Width:0] word_t;

    logic             bus_clk = 1'b0;
    logic             bus_rst;
    logic             clear;
    logic [Width-1:0] i_tdata;
    logic             i_tlast;
    logic             i_tvalid;
    logic             i_tready;
    logic [Width-1:0] o_tdata;
    logic             o_tlast;
    logic             o_tvalid;
    logic             o_tready;
    logic [CntW-1:0]  pkt_count;
    logic             drop_pulse;
`ifdef S2H_PKT_GATE_STATS_EN
    logic [31:0]      drop_total;
    logic [31:0]      fwd_total;
`endif

    s2h_pkt_gate #(
        .WIDTH    (Width),
        .SIZE     (Size),
        .PKT_CNT_W(CntW)
    ) dut (
        .bus_clk   (bus_clk),
        .bus_rst   (bus_rst),
        .clear     (clear),
        .i_tdata   (i_tdata),
        .i_tlast   (i_tlast),
        .i_tvalid  (i_tvalid),
        .i_tready  (i_tready),
        .o_tdata   (o_tdata),
        .o_tlast   (o_tlast),
        .o_tvalid  (o_tvalid),
        .o_tready  (o_tready),
        .pkt_count (pkt_count),
        .drop_pulse(drop_pulse)
`ifdef S2H_PKT_GATE_STATS_EN
        ,
        .drop_total(drop_total),
        .fwd_total (fwd_total)
`endif
    );

    always #5 bus_clk = ~bus_clk;

    int n_checks = 0;
    int n_fails  = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model state
    word_t exp_q[$];
    word_t part_q[$];
    int    model_drops  = 0;
    int    fwd_model    = 0;
    int    drop_seen    = 0;
    int    hs_count     = 0;
    int    acc_total    = 0;
    int    stall_cycles = 0;
    int    cyc          = 0;
    int    first_hs     = -1;
    int    last_hs      = -1;
    int    max_cnt      = 0;
    int    rdy_mode     = 1;  // 0: hold low, 1: always ready, 2: random

    // Downstream ready generator
    always @(posedge bus_clk) begin
        #1;
        case (rdy_mode)
            0:       o_tready = 1'b0;
            1:       o_tready = 1'b1;
            default: o_tready = ($urandom_range(0, 3) != 0);
        endcase
    end

    // Monitor and packet-level model, sampled mid-cycle
    always @(negedge bus_clk) begin
        word_t w;
        cyc++;
        if (drop_pulse) drop_seen++;
        if (bus_rst || clear) begin
            exp_q.delete();
            part_q.delete();
        end else begin
            if (o_tvalid && o_tready) begin
                hs_count++;
                if (first_hs < 0) first_hs = cyc;
                last_hs = cyc;
                check("out_expected", 128'(exp_q.size() > 0), 128'(1));
                if (exp_q.size() > 0) begin
                    w = exp_q.pop_front();
                    check("out_word", 128'({o_tlast, o_tdata}), 128'(w));
                    if (w[Width]) fwd_model++;
                end
            end
            if (i_tvalid && i_tready) begin
                acc_total++;
                part_q.push_back({i_tlast, i_tdata});
                if (i_tlast) begin
                    if (part_q.size() > Depth) model_drops++;
                    else foreach (part_q[k]) exp_q.push_back(part_q[k]);
                    part_q.delete();
                end
            end
            if (int'(pkt_count) > max_cnt) max_cnt = int'(pkt_count);
        end
    end

    task automatic tick();
        @(posedge bus_clk);
        #1;
    endtask

    task automatic idle(input int n);
        i_tvalid = 1'b0;
        i_tlast  = 1'b0;
        repeat (n) tick();
    endtask

    // Present one word and hold it until accepted (bounded)
    task automatic send_word(input word_t w);
        bit acc;
        int n;
        i_tvalid = 1'b1;
        i_tlast  = w[Width];
        i_tdata  = w[Width-1:0];
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 300) begin
            @(negedge bus_clk);
            acc = i_tready;
            tick();
            if (!acc) stall_cycles++;
            n++;
        end
        check("in_accept", 128'(acc), 128'(1));
    endtask

    task automatic send_pkt(input int len, input bit gaps);
        word_t w;
        for (int i = 0; i < len; i++) begin
            w = {1'b0, 32'($urandom()), 32'($urandom())};
            w[Width] = (i == len - 1);
            send_word(w);
            if (gaps && $urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
        end
        i_tvalid = 1'b0;
        i_tlast  = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((exp_q.size() != 0 || o_tvalid) && n < 2000) begin
            tick();
            n++;
        end
        check(tag, 128'(exp_q.size()), 128'(0));
    endtask

    initial begin
        int  d0, h0, a0;
        bit  seen;
        word_t w;
        bus_rst  = 1'b1;
        clear    = 1'b0;
        i_tvalid = 1'b0;
        i_tlast  = 1'b0;
        i_tdata  = '0;

        // Reset state
        repeat (3) @(posedge bus_clk);
        @(negedge bus_clk);
        check("rst_i_tready", 128'(i_tready), 128'(0));
        check("rst_o_tvalid", 128'(o_tvalid), 128'(0));
        check("rst_o_tlast", 128'(o_tlast), 128'(0));
        check("rst_o_tdata", 128'(o_tdata), 128'(0));
        check("rst_pkt_count", 128'(pkt_count), 128'(0));
        check("rst_drop_pulse", 128'(drop_pulse), 128'(0));
        tick();
        bus_rst = 1'b0;
        @(negedge bus_clk);
        check("post_rst_i_tready", 128'(i_tready), 128'(1));
        tick();

        // 5-word packet: nothing visible until tlast, then a 5-word burst
        for (int i = 0; i < 4; i++) send_word({1'b0, 32'($urandom()), 32'($urandom())});
        idle(3);
        @(negedge bus_clk);
        check("t1_no_early_vld", 128'(o_tvalid), 128'(0));
        check("t1_cnt_zero", 128'(pkt_count), 128'(0));
        tick();
        send_word({1'b1, 32'($urandom()), 32'($urandom())});
        i_tvalid = 1'b0;
        i_tlast  = 1'b0;
        @(negedge bus_clk);
        check("t1_cnt_one", 128'(pkt_count), 128'(1));
        seen = o_tvalid;
        if (!seen) begin
            @(negedge bus_clk);
            seen = o_tvalid;
        end
        check("t1_latency", 128'(seen), 128'(1));
        if (seen) begin
            for (int k = 0; k < 5; k++) begin
                check("t1_stream", 128'(o_tvalid), 128'(1));
                @(negedge bus_clk);
            end
            check("t1_cnt_back_zero", 128'(pkt_count), 128'(0));
        end
        tick();
        drain("t1_drain");

        // Oversize 20-word packet dropped without backpressure, then a 3-word packet
        stall_cycles = 0;
        d0 = drop_seen;
        h0 = hs_count;
        send_pkt(20, 1'b0);
        idle(4);
        check("t2_no_stall", 128'(stall_cycles), 128'(0));
        check("t2_one_drop", 128'(drop_seen - d0), 128'(1));
        check("t2_no_output", 128'(hs_count - h0), 128'(0));
        send_pkt(3, 1'b0);
        drain("t2_drain");

        // Backpressure: two 10-word packets with the sink stalled
        rdy_mode = 0;
        idle(2);
        a0 = acc_total;
        fork
            begin
                send_pkt(10, 1'b0);
                send_pkt(10, 1'b0);
            end
            begin
                repeat (40) @(posedge bus_clk);
                @(negedge bus_clk);
                check("t3_accepted", 128'(acc_total - a0), 128'(16));
                check("t3_stalled", 128'(i_tready), 128'(0));
                check("t3_cnt", 128'(pkt_count), 128'(1));
                tick();
                rdy_mode = 1;
            end
        join
        drain("t3_drain");

        // Back-to-back single-word packets stream at one word per cycle
        idle(2);
        h0 = hs_count;
        first_hs = -1;
        max_cnt = 0;
        stall_cycles = 0;
        for (int i = 0; i < 20; i++) send_word({1'b1, 32'($urandom()), 32'($urandom())});
        idle(1);
        drain("t4_drain");
        check("t4_count", 128'(hs_count - h0), 128'(20));
        check("t4_rate", 128'(last_hs - first_hs), 128'(19));
        check("t4_max_cnt", 128'(max_cnt <= 2), 128'(1));
        check("t4_no_stall", 128'(stall_cycles), 128'(0));

        // Packet counter saturation blocks further input
        rdy_mode = 0;
        idle(2);
        for (int i = 0; i < 7; i++) send_word({1'b1, 32'($urandom()), 32'($urandom())});
        idle(2);
        @(negedge bus_clk);
        check("sat_cnt", 128'(pkt_count), 128'(7));
        check("sat_not_ready", 128'(i_tready), 128'(0));
        tick();
        a0 = acc_total;
        fork
            send_word({1'b1, 32'($urandom()), 32'($urandom())});
            begin
                repeat (5) tick();
                check("sat_held_off", 128'(acc_total - a0), 128'(0));
                rdy_mode = 1;
            end
        join
        idle(1);
        drain("sat_drain");

        // Clear with a partly read packet and a partly written packet
        rdy_mode = 0;
        idle(2);
        send_pkt(6, 1'b0);
        idle(3);
        rdy_mode = 1;
        repeat (2) tick();
        rdy_mode = 0;
        for (int i = 0; i < 3; i++) send_word({1'b0, 32'($urandom()), 32'($urandom())});
        idle(3);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        @(negedge bus_clk);
        check("clr_o_tvalid", 128'(o_tvalid), 128'(0));
        check("clr_pkt_count", 128'(pkt_count), 128'(0));
        tick();
        rdy_mode = 1;
        send_pkt(4, 1'b0);
        drain("clr_drain");

        // Randomized traffic with random sink stalls and occasional oversize packets
        rdy_mode = 2;
        for (int p = 0; p < 25; p++) send_pkt(int'($urandom_range(1, 22)), 1'b1);
        rdy_mode = 1;
        idle(1);
        drain("rnd_drain");
        idle(3);
        check("rnd_drops", 128'(drop_seen), 128'(model_drops));
        check("rnd_cnt_zero", 128'(pkt_count), 128'(0));

`ifdef S2H_PKT_GATE_STATS_EN
        @(negedge bus_clk);
        check("stats_fwd", 128'(fwd_total), 128'(fwd_model));
        check("stats_drop", 128'(drop_total), 128'(model_drops));
        tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        @(negedge bus_clk);
        check("stats_fwd_clear", 128'(fwd_total), 128'(fwd_model));
        check("stats_drop_clear", 128'(drop_total), 128'(model_drops));
        tick();
`endif

        // Reset in the middle of an input packet
        d0 = drop_seen;
        for (int i = 0; i < 3; i++) send_word({1'b0, 32'($urandom()), 32'($urandom())});
        i_tvalid = 1'b0;
        bus_rst  = 1'b1;
        @(negedge bus_clk);
        check("mid_rst_i_tready", 128'(i_tready), 128'(0));
        check("mid_rst_o_tvalid", 128'(o_tvalid), 128'(0));
        check("mid_rst_cnt", 128'(pkt_count), 128'(0));
        tick();
        bus_rst = 1'b0;
        fwd_model = 0;
        model_drops = 0;
        idle(3);
        check("mid_rst_no_drop", 128'(drop_seen - d0), 128'(0));
`ifdef S2H_PKT_GATE_STATS_EN
        check("rst_fwd_total", 128'(fwd_total), 128'(0));
        check("rst_drop_total", 128'(drop_total), 128'(0));
`endif
        send_pkt(2, 1'b0);
        drain("post_rst_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    // Global time bound
    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
